// File: rtl/dmem_pkg.sv
// Shared types and widths for the data-memory store buffer.
package dmem_pkg;

    localparam int unsigned DMEM_AW = 8;
    localparam int unsigned DMEM_DW = 32;
    localparam int unsigned DMEM_NB = DMEM_DW / 8;

    typedef struct packed {
        logic [DMEM_AW-1:0] addr;
        logic [DMEM_NB-1:0] mask;
        logic [DMEM_DW-1:0] data;
    } sb_entry_t;

endpackage

// File: rtl/sb_fwd_merge.sv
// Per-byte youngest-match select over the pending stores, used to forward
// queued data to a load that hits an address still sitting in the buffer.
module sb_fwd_merge
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned PW    = $clog2(DEPTH)
) (
    input  sb_entry_t [DEPTH-1:0] entries,
    input  logic [DEPTH-1:0]      valid,
    input  logic [PW-1:0]         head,
    input  logic [DMEM_AW-1:0]    raddr,
    output logic [DMEM_NB-1:0]    fwd_mask,
    output logic [DMEM_DW-1:0]    fwd_data
);

    logic [PW-1:0] idx;

    // Walk oldest to youngest so later matches overwrite earlier ones.
    always_comb begin
        fwd_mask = '0;
        fwd_data = '0;
        idx      = '0;
        for (int unsigned k = 0; k < DEPTH; k++) begin
            idx = head + PW'(k);
            if (valid[idx] && (entries[idx].addr == raddr)) begin
                for (int unsigned b = 0; b < DMEM_NB; b++) begin
                    if (entries[idx].mask[b]) begin
                        fwd_mask[b]          = 1'b1;
                        fwd_data[b*8 +: 8]   = entries[idx].data[b*8 +: 8];
                    end
                end
            end
        end
    end

endmodule

// File: rtl/dmem_store_buffer.sv
// Posted-write store buffer: queues core stores, drains one per cycle to SRAM
// port 0, and merges pending store bytes into loads served by SRAM port 1.
module dmem_store_buffer
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned AW    = DMEM_AW,
    parameter int unsigned DW    = DMEM_DW
) (
    input  logic            clk_i,
    input  logic            reset_i,
    input  logic            core_csb_write_i,
    input  logic [DW/8-1:0] core_wmask_i,
    input  logic [AW-1:0]   core_waddr_i,
    input  logic [DW-1:0]   core_din_i,
    input  logic            core_csb_read_i,
    input  logic [AW-1:0]   core_raddr_i,
    output logic [DW-1:0]   core_dout_o,
    output logic            sb_full_o,
    output logic            sb_empty_o,
    output logic            sram_csb0_o,
    output logic [DW/8-1:0] sram_wmask0_o,
    output logic [AW-1:0]   sram_addr0_o,
    output logic [DW-1:0]   sram_din0_o,
    output logic            sram_csb1_o,
    output logic [AW-1:0]   sram_addr1_o,
    input  logic [DW-1:0]   sram_dout1_i
);

    localparam int unsigned NB = DW / 8;
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    sb_entry_t [DEPTH-1:0] entries;
    sb_entry_t             head_entry;
    logic [DEPTH-1:0]      valid;
    logic [PW-1:0]         head;
    logic [PW-1:0]         tail;
    logic [CW-1:0]         count;
    logic [NB-1:0]         fwd_mask;
    logic [NB-1:0]         fwd_mask_q;
    logic [DW-1:0]         fwd_data;
    logic [DW-1:0]         fwd_data_q;
    logic                  hold;
    logic                  push;
    logic                  pop;

    assign head_entry = entries[head];
    assign sb_empty_o = (count == '0);
    assign sb_full_o  = (count == CW'(DEPTH));

    // A pending write to the address being read must wait: the SRAM read port
    // returns pre-write data, and the forward path already covers that load.
    assign hold = !core_csb_read_i && (core_raddr_i == head_entry.addr);
    assign pop  = !sb_empty_o && !hold;
    assign push = !core_csb_write_i && !sb_full_o;

    assign sram_csb0_o   = !pop;
    assign sram_wmask0_o = head_entry.mask;
    assign sram_addr0_o  = head_entry.addr;
    assign sram_din0_o   = head_entry.data;
    assign sram_csb1_o   = core_csb_read_i;
    assign sram_addr1_o  = core_raddr_i;

    sb_fwd_merge #(
        .DEPTH (DEPTH),
        .PW    (PW)
    ) u_fwd_merge (
        .entries  (entries),
        .valid    (valid),
        .head     (head),
        .raddr    (core_raddr_i),
        .fwd_mask (fwd_mask),
        .fwd_data (fwd_data)
    );

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            entries    <= '0;
            valid      <= '0;
            head       <= '0;
            tail       <= '0;
            count      <= '0;
            fwd_mask_q <= '0;
            fwd_data_q <= '0;
        end else begin
            if (push) begin
                entries[tail] <= '{addr: core_waddr_i, mask: core_wmask_i, data: core_din_i};
                valid[tail]   <= 1'b1;
                tail          <= tail + PW'(1);
            end
            if (pop) begin
                valid[head] <= 1'b0;
                head        <= head + PW'(1);
            end
            count      <= count + CW'(push) - CW'(pop);
            fwd_mask_q <= core_csb_read_i ? '0 : fwd_mask;
            fwd_data_q <= fwd_data;
        end
    end

    // Forwarded bytes override the SRAM read data one cycle after the load.
    always_comb begin
        core_dout_o = sram_dout1_i;
        for (int unsigned b = 0; b < NB; b++) begin
            if (fwd_mask_q[b]) begin
                core_dout_o[b*8 +: 8] = fwd_data_q[b*8 +: 8];
            end
        end
    end

endmodule

// File: tb/tb_dmem_store_buffer.sv
// Bench for dmem_store_buffer: acts as the SRAM and checks the DUT every cycle
// against a FIFO-of-stores plus program-order memory model.
module tb_dmem_store_buffer;
    import dmem_pkg::*;

    localparam int unsigned DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        csb_w;
    logic [3:0]  wmask;
    logic [7:0]  waddr;
    logic [31:0] din;
    logic        csb_r;
    logic [7:0]  raddr;
    logic [31:0] core_dout;
    logic        full;
    logic        empty;
    logic        csb0;
    logic [3:0]  wmask0;
    logic [7:0]  addr0;
    logic [31:0] din0;
    logic        csb1;
    logic [7:0]  addr1;
    logic [31:0] sram_dout1 = '0;

    int n_cmp = 0;
    int n_bad = 0;
    int n_wr  = 0;

    logic [31:0] sram_mem [256];
    logic [31:0] arch_mem [256];
    logic [39:0] wlog [$];
    sb_entry_t   q [$];

    logic        prev_load = 1'b0;
    logic [31:0] exp_load  = '0;
    logic        m_hold;
    logic        m_drain;
    logic        m_accept;

    always #5 clk = ~clk;

    dmem_store_buffer #(.DEPTH(DEPTH), .AW(8), .DW(32)) dut (
        .clk_i            (clk),
        .reset_i          (rst_n),
        .core_csb_write_i (csb_w),
        .core_wmask_i     (wmask),
        .core_waddr_i     (waddr),
        .core_din_i       (din),
        .core_csb_read_i  (csb_r),
        .core_raddr_i     (raddr),
        .core_dout_o      (core_dout),
        .sb_full_o        (full),
        .sb_empty_o       (empty),
        .sram_csb0_o      (csb0),
        .sram_wmask0_o    (wmask0),
        .sram_addr0_o     (addr0),
        .sram_din0_o      (din0),
        .sram_csb1_o      (csb1),
        .sram_addr1_o     (addr1),
        .sram_dout1_i     (sram_dout1)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // 1rw1r SRAM: port-1 read has one cycle latency, port-0 byte-masked write.
    always @(posedge clk) begin
        if (!csb1) sram_dout1 <= sram_mem[addr1];
        if (!csb0) begin
            for (int b = 0; b < 4; b++)
                if (wmask0[b]) sram_mem[addr0][b*8 +: 8] <= din0[b*8 +: 8];
            n_wr++;
            wlog.push_back({addr0, din0});
        end
    end

    // Model: pending stores as a queue, loads see program-order memory.
    always @(negedge clk) begin
        if (!rst_n) begin
            q.delete();
            arch_mem  = sram_mem;
            prev_load = 1'b0;
            check("rst_empty", 64'(empty), 64'd1);
            check("rst_full", 64'(full), 64'd0);
            check("rst_csb0", 64'(csb0), 64'd1);
        end else begin
            if (prev_load) check("load_data", 64'(core_dout), 64'(exp_load));
            check("empty", 64'(empty), 64'(q.size() == 0));
            check("full", 64'(full), 64'(q.size() == DEPTH));
            check("csb1", 64'(csb1), 64'(csb_r));
            if (!csb_r) check("addr1", 64'(addr1), 64'(raddr));
            m_hold  = !csb_r && (q.size() > 0) && (raddr == q[0].addr);
            m_drain = (q.size() > 0) && !m_hold;
            check("csb0", 64'(csb0), 64'(!m_drain));
            if (m_drain) begin
                check("addr0", 64'(addr0), 64'(q[0].addr));
                check("wmask0", 64'(wmask0), 64'(q[0].mask));
                check("din0", 64'(din0), 64'(q[0].data));
            end
            m_accept  = !csb_w && (q.size() < DEPTH);
            prev_load = !csb_r;
            if (!csb_r) exp_load = arch_mem[raddr];
            if (m_drain) void'(q.pop_front());
            if (m_accept) begin
                q.push_back('{addr: waddr, mask: wmask, data: din});
                for (int b = 0; b < 4; b++)
                    if (wmask[b]) arch_mem[waddr][b*8 +: 8] = din[b*8 +: 8];
            end
        end
    end

    task automatic set_in(input logic w, input logic [7:0] wa, input logic [3:0] m,
                          input logic [31:0] d, input logic r, input logic [7:0] ra);
        csb_w = !w; waddr = wa; wmask = m; din = d; csb_r = !r; raddr = ra;
    endtask

    task automatic idle();
        set_in(1'b0, 8'h00, 4'h0, 32'h0, 1'b0, 8'h00);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    int wr_snap;

    initial begin
        for (int i = 0; i < 256; i++) sram_mem[i] = {4{8'(i)}};
        sram_mem[8'h30] = 32'h11223344;
        sram_mem[8'h50] = 32'h00000000;
        rst_n = 1'b0;
        idle();
        repeat (2) @(posedge clk);
        #1;
        check("lit_rst_empty", 64'(empty), 64'd1);
        check("lit_rst_csb0", 64'(csb0), 64'd1);
        check("lit_rst_dout", 64'(core_dout), 64'(sram_dout1));
        rst_n = 1'b1;

        // Single store drains the following cycle.
        set_in(1'b1, 8'h10, 4'hF, 32'hDEADBEEF, 1'b0, 8'h00);
        step();
        idle();
        #1;
        check("t1_csb0", 64'(csb0), 64'd0);
        check("t1_addr0", 64'(addr0), 64'h10);
        check("t1_wmask0", 64'(wmask0), 64'hF);
        check("t1_din0", 64'(din0), 64'hDEADBEEF);
        step();
        check("t1_empty", 64'(empty), 64'd1);
        check("t1_mem", 64'(sram_mem[8'h10]), 64'hDEADBEEF);

        // Loads to the head address hold the drain until the buffer fills.
        for (int k = 1; k <= 4; k++) begin
            set_in(1'b1, 8'h20, 4'hF, 32'(k), 1'b1, 8'h20);
            step();
        end
        set_in(1'b1, 8'h20, 4'hF, 32'd5, 1'b1, 8'h20);
        #1;
        check("t2_full", 64'(full), 64'd1);
        check("t2_held", 64'(csb0), 64'd1);
        step();
        idle();
        for (int k = 1; k <= 4; k++) begin
            #1;
            check("t2_drain_order", 64'(din0), 64'(k));
            step();
        end
        check("t2_empty", 64'(empty), 64'd1);
        check("t2_mem", 64'(sram_mem[8'h20]), 64'd4);

        // Partial-mask forward merged with SRAM bytes.
        set_in(1'b1, 8'h30, 4'b0011, 32'h0000ABCD, 1'b0, 8'h00);
        step();
        set_in(1'b0, 8'h00, 4'h0, 32'h0, 1'b1, 8'h30);
        step();
        idle();
        #1;
        check("t3_merge", 64'(core_dout), 64'h1122ABCD);
        step();
        step();

        // Youngest matching store wins; SRAM sees both writes in order.
        wlog.delete();
        set_in(1'b1, 8'h40, 4'b0001, 32'h000000AA, 1'b1, 8'h40);
        step();
        set_in(1'b1, 8'h40, 4'b0001, 32'h000000BB, 1'b1, 8'h40);
        step();
        set_in(1'b0, 8'h00, 4'h0, 32'h0, 1'b1, 8'h40);
        step();
        idle();
        #1;
        check("t4_youngest", 64'(core_dout[7:0]), 64'hBB);
        step();
        step();
        check("t4_wcount", 64'(wlog.size()), 64'd2);
        if (wlog.size() == 2) begin
            check("t4_w0", 64'(wlog[0]), 64'h40_000000AA);
            check("t4_w1", 64'(wlog[1]), 64'h40_000000BB);
        end
        check("t4_mem", 64'(sram_mem[8'h40]), 64'h404040BB);

        // Reset mid-drain discards the queue immediately.
        set_in(1'b1, 8'h60, 4'hF, 32'h60606061, 1'b1, 8'h60);
        step();
        set_in(1'b1, 8'h61, 4'hF, 32'h61616162, 1'b1, 8'h60);
        step();
        set_in(1'b1, 8'h62, 4'hF, 32'h62626263, 1'b1, 8'h60);
        step();
        idle();
        step();
        #1;
        rst_n = 1'b0;
        #1;
        check("t5_empty", 64'(empty), 64'd1);
        check("t5_csb0", 64'(csb0), 64'd1);
        wr_snap = n_wr;
        step();
        step();
        rst_n = 1'b1;
        repeat (3) step();
        check("t5_no_writes", 64'(n_wr), 64'(wr_snap));
        check("t5_mem61", 64'(sram_mem[8'h61]), 64'h61616161);

        // Same-cycle store is invisible to the load; next load forwards it.
        set_in(1'b1, 8'h50, 4'hF, 32'h12345678, 1'b1, 8'h50);
        step();
        set_in(1'b0, 8'h00, 4'h0, 32'h0, 1'b1, 8'h50);
        #1;
        check("t6_read_first", 64'(core_dout), 64'h0);
        step();
        idle();
        #1;
        check("t6_forward", 64'(core_dout), 64'h12345678);
        step();
        step();

        // Zero-mask store never forwards.
        set_in(1'b1, 8'h70, 4'h0, 32'hFFFFFFFF, 1'b0, 8'h00);
        step();
        set_in(1'b0, 8'h00, 4'h0, 32'h0, 1'b1, 8'h70);
        step();
        idle();
        #1;
        check("t7_zero_mask", 64'(core_dout), 64'h70707070);
        step();

        // Back-to-back mixed traffic across pointer wrap.
        for (int i = 0; i < 10; i++) begin
            set_in(1'b1, 8'(8'h80 + i % 3), 4'((1 << (i % 4)) | 1), 32'(32'h01010101 * (i + 1)),
                   1'(i % 2), 8'(8'h80 + (i + 1) % 3));
            step();
        end
        idle();
        repeat (8) step();
        check("burst_empty", 64'(empty), 64'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
